// File: rtl/req_sequencer_pkg.sv
// Shared constants and FSM state encoding for the request sequencer.
package req_sequencer_pkg;

  localparam int unsigned NREQ_C = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/req_sequencer_prio_enc8.sv
// 8-to-3 priority encoder; bit 7 has the highest priority.
module prio_enc8 (
  input  logic [7:0] in,
  output logic [2:0] code,
  output logic       any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    code = 3'd0;
    any  = |in;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) code = 3'(i);
    end
  end

endmodule

// File: rtl/req_sequencer.sv
// Captures rising edges on request lines into a pending vector and grants
// them one at a time, highest index first, with an Ack handshake.
module req_sequencer
  import req_sequencer_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_C
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [NREQ-1:0]   In,
  input  logic [NREQ-1:0]   Mask,
  output logic [CODE_W-1:0] Y,
  output logic              Done,
  input  logic              Ack,
  output logic [NREQ-1:0]   Pending,
  output logic              Ovf
);

  state_t              state;
  state_t              state_nxt;
  logic [NREQ-1:0]     in_d;
  logic [NREQ-1:0]     evt;
  logic [NREQ-1:0]     set_v;
  logic [NREQ-1:0]     clr_v;
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     pending_nxt;
  logic                ovf_nxt;
  logic [CODE_W-1:0]   enc_code;
  logic                enc_any;
  logic [CODE_W-1:0]   y_nxt;
  logic                done_nxt;

  prio_enc8 u_prio_enc (
    .in   (eligible),
    .code (enc_code),
    .any  (enc_any)
  );

  // Edge detect, pending set/clear (set wins over an Ack-clear) and overflow.
  always_comb begin
    evt   = In & ~in_d;
    set_v = EN ? evt : '0;
    clr_v = '0;
    if (state == GRANT && Ack) clr_v[Y] = 1'b1;
    pending_nxt = (Pending & ~clr_v) | set_v;
    ovf_nxt     = Ovf | (|(set_v & Pending & ~clr_v));
    eligible    = Pending & ~Mask;
  end

  // Next-state and registered-output values for the grant FSM.
  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    done_nxt  = Done;
    case (state)
      IDLE: begin
        done_nxt = 1'b0;
        if (EN && enc_any) begin
          state_nxt = GRANT;
          y_nxt     = enc_code;
          done_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (Ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      in_d    <= '0;
      Pending <= '0;
      Ovf     <= 1'b0;
      Y       <= '0;
      Done    <= 1'b0;
    end else begin
      in_d    <= In;
      Pending <= pending_nxt;
      Ovf     <= ovf_nxt;
      Y       <= y_nxt;
      Done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_req_sequencer.sv
// Directed self-checking bench for req_sequencer with a grant-order scoreboard.
module tb_req_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [7:0] In;
  logic [7:0] Mask;
  logic [2:0] Y;
  logic       Done;
  logic       Ack;
  logic [7:0] Pending;
  logic       Ovf;

  int checks;
  int errors;
  logic [2:0] exp_q[$];
  logic [2:0] exp_y;

  req_sequencer #(.NREQ(8)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .In      (In),
    .Mask    (Mask),
    .Y       (Y),
    .Done    (Done),
    .Ack     (Ack),
    .Pending (Pending),
    .Ovf     (Ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (Done === 1'b1) break;
      tick();
    end
    check(tag, 8'(Done), 8'h01);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N = 1'b0; EN = 1'b0; In = 8'h00; Mask = 8'h00; Ack = 1'b0;
    tick(); tick();
    check("rst_done", 8'(Done), 8'h00);
    check("rst_y", 8'(Y), 8'h00);
    check("rst_pending", Pending, 8'h00);
    check("rst_ovf", 8'(Ovf), 8'h00);
    RST_N = 1'b1;
    tick();

    // Single request: capture, grant, ack.
    EN = 1'b1; In = 8'h08;
    tick();
    check("single_pend", Pending, 8'h08);
    check("single_nodone", 8'(Done), 8'h00);
    tick();
    check("single_done", 8'(Done), 8'h01);
    check("single_y", 8'(Y), 8'h03);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("single_clr", Pending, 8'h00);
    check("single_undone", 8'(Done), 8'h00);
    In = 8'h00;
    tick();

    // Multiple simultaneous requests drain in priority order.
    In = 8'h39;
    exp_q.push_back(3'd5); exp_q.push_back(3'd4);
    exp_q.push_back(3'd3); exp_q.push_back(3'd0);
    tick();
    check("multi_pend", Pending, 8'h39);
    check("multi_idle0", 8'(Done), 8'h00);
    while (exp_q.size() > 0) begin
      exp_y = exp_q.pop_front();
      wait_done("multi_done");
      check("multi_y", 8'(Y), 8'(exp_y));
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      check("multi_gap", 8'(Done), 8'h00);
    end
    check("multi_drain", Pending, 8'h00);
    In = 8'h00;
    tick();

    // Events while disabled are discarded.
    EN = 1'b0; In = 8'h81;
    tick(); tick();
    check("dis_pend", Pending, 8'h00);
    check("dis_done", 8'(Done), 8'h00);
    check("dis_ovf", 8'(Ovf), 8'h00);
    In = 8'h00;
    tick();
    EN = 1'b1;

    // Masking holds off a grant; Ack in IDLE is ignored.
    Mask = 8'h10; In = 8'h10;
    tick();
    check("mask_pend", Pending, 8'h10);
    tick(); tick();
    check("mask_nodone", 8'(Done), 8'h00);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("idle_ack_pend", Pending, 8'h10);
    Mask = 8'h00;
    tick();
    check("unmask_done", 8'(Done), 8'h01);
    check("unmask_y", 8'(Y), 8'h04);
    // Masking and disabling after grant leave the grant intact.
    Mask = 8'h10; EN = 1'b0;
    tick();
    check("postmask_done", 8'(Done), 8'h01);
    check("postmask_y", 8'(Y), 8'h04);
    EN = 1'b1;
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("postmask_clr", Pending, 8'h00);
    check("postmask_undone", 8'(Done), 8'h00);
    Mask = 8'h00; In = 8'h00;
    tick();

    // Set beats Ack-clear; a second edge on a pending bit sets Ovf.
    In = 8'h08;
    tick();
    tick();
    check("race_y", 8'(Y), 8'h03);
    In = 8'h00;
    tick();
    Ack = 1'b1; In = 8'h08;
    tick();
    Ack = 1'b0;
    check("race_pend", Pending, 8'h08);
    check("race_ovf", 8'(Ovf), 8'h00);
    check("race_gap", 8'(Done), 8'h00);
    In = 8'h00;
    tick();
    check("regrant_done", 8'(Done), 8'h01);
    In = 8'h08;
    tick();
    check("ovf_set", 8'(Ovf), 8'h01);
    check("ovf_pend", Pending, 8'h08);
    tick();
    check("ovf_sticky", 8'(Ovf), 8'h01);

    // Reset aborts a grant; high inputs count as events after release.
    In = 8'h00;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    In = 8'h18;
    tick();
    check("abort_pend", Pending, 8'h18);
    tick();
    check("abort_pre_done", 8'(Done), 8'h01);
    check("abort_pre_y", 8'(Y), 8'h04);
    RST_N = 1'b0;
    tick();
    check("abort_done", 8'(Done), 8'h00);
    check("abort_pend0", Pending, 8'h00);
    check("abort_ovf", 8'(Ovf), 8'h00);
    check("abort_y", 8'(Y), 8'h00);
    RST_N = 1'b1;
    tick();
    check("post_rst_evt", Pending, 8'h18);
    check("post_rst_idle", 8'(Done), 8'h00);
    tick();
    check("post_rst_grant", 8'(Y), 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_sequencer.md
REQ_SEQUENCER -- requirements
Module: req_sequencer

Interface
REQ-001 SHALL have parameter NREQ, default 8, number of request lines; fixed at 8, with a 3-bit grant code.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port EN, input, 1, capture/grant enable.
REQ-005 SHALL have port In, input, 8, request lines; a rising edge on a bit is one event.
REQ-006 SHALL have port Mask, input, 8; a 1 suppresses granting of that bit but not its capture.
REQ-007 SHALL have port Y, output, 3, granted request index.
REQ-008 SHALL have port Done, output, 1, grant valid; Y is meaningful only while Done=1.
REQ-009 SHALL have port Ack, input, 1, consumer accepts the current grant.
REQ-010 SHALL have port Pending, output, 8, registered pending-event vector.
REQ-011 SHALL have port Ovf, output, 1, sticky flag for an event lost on an already-pending bit.

Function
REQ-012 SHALL register In into In_d each cycle; event[i] = In[i] & ~In_d[i].
REQ-013 SHALL set Pending[i] at the edge on which event[i]=1 and EN=1; events with EN=0 are discarded and Ovf is not set.
REQ-014 SHALL set Ovf when event[i]=1, EN=1 and Pending[i] was already 1 and not being cleared in the same cycle.
REQ-015 SHALL compute the eligible vector = Pending & ~Mask and priority-encode it combinationally; bit 7 is highest priority.
REQ-016 SHALL use a two-state FSM: IDLE and GRANT.
REQ-017 In IDLE, when EN=1 and eligible!=0, the FSM SHALL load Y with the encoder output, assert Done and enter GRANT at the same edge.
REQ-018 In IDLE with EN=0 or eligible==0, the FSM SHALL stay in IDLE with Done=0 and Y holding its last value.
REQ-019 In GRANT, Done=1 and Y SHALL stay stable regardless of changes to In, Mask or EN.
REQ-020 In GRANT with Ack=1, the FSM SHALL clear Pending[Y], deassert Done and return to IDLE at that edge; at least one IDLE cycle separates consecutive grants.
REQ-021 Ack in IDLE SHALL be ignored.
REQ-022 When a new event and an Ack-clear hit the same bit in the same cycle, set SHALL win: Pending stays 1 and Ovf is not set.
REQ-023 Latency: a first sampled edge at clock k sets Pending after k; Done rises after k+1 when EN=1 and the bit is unmasked and highest priority.
REQ-024 A bit masked after being granted SHALL still complete its grant; its Pending bit clears on Ack.

Reset
REQ-025 At a rising CLK edge with RST_N=0: FSM=IDLE, Y=3'b000, Done=0, Pending=8'h00, Ovf=0, In_d=8'h00.
REQ-026 Reset asserted mid-GRANT SHALL abort the grant without requiring Ack; after release the block starts in IDLE.
REQ-027 In_d=0 after reset means any In bit already high counts as a new event at the first post-reset edge, provided EN=1.

Structure
REQ-028 A shared package SHALL hold the NREQ and code-width constants and the FSM state enum (IDLE, GRANT).
REQ-029 The priority encoder SHALL be a separate combinational sub-module, prio_enc8 (in[7:0] -> code[2:0], any); it is instantiated once.

Verification
REQ-030 Reset, then EN=1, In 00000000->00001000 -> Pending=08 after one edge, then Done=1 and Y=3; Ack -> Pending=00, Done=0.
REQ-031 EN=1, In steps to 00111001 in one cycle -> grants in order Y=5,4,3,0, each ended by Ack, with an IDLE cycle between grants.
REQ-032 EN=0, In 00000000->10000001 -> Pending stays 00, Done=0, Ovf=0.
REQ-033 Pending[4]=1, Mask=00010000 -> no Done; Mask=00 -> Done=1, Y=4.
REQ-034 During GRANT Y=3, In[3] toggles 0->1 in the Ack cycle -> Pending[3] stays 1 and Ovf=0; a second edge without Ack -> Ovf=1.
REQ-035 RST_N=0 during GRANT with Pending=18 -> next edge Done=0, Pending=00, Ovf=0, Y=0.
